// File: rtl/alarm_disp_pkg.sv
// Shared types and constants for the alarm display stage.
package alarm_disp_pkg;

  typedef enum logic [2:0] {
    ST_SAMPLE,
    ST_MIN,
    ST_SEC,
    ST_DIGIT,
    ST_COMMIT
  } state_t;

  localparam logic [15:0] CS_PER_MIN = 16'd6000;
  localparam logic [15:0] CS_PER_SEC = 16'd100;
  localparam logic [6:0]  SEG_BLANK  = 7'h7F;

  // Active-low segment pattern for one decimal digit (bit0=a .. bit6=g).
  function automatic logic [6:0] seg_lut(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h10;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/alarm_display_seg7_decode.sv
// Combinational digit-to-segment decoder with a blank override.
module seg7_decode
  import alarm_disp_pkg::*;
(
  input  logic [3:0] digit,
  input  logic       blank,
  output logic [6:0] seg
);

  assign seg = blank ? SEG_BLANK : seg_lut(digit);

endmodule

// File: rtl/alarm_display.sv
// Six-digit MM:SS.cc display driver with blink blanking and piezo tone.
// Binary centiseconds are converted by repeated subtraction; all six
// digits are committed together so the display never shows a torn value.
module alarm_display
  import alarm_disp_pkg::*;
#(
  parameter int unsigned BLINK_HALF_CYCLES = 12_500_000,
  parameter int unsigned TONE_HALF_CYCLES  = 25_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] value,
  input  logic        flashOn,
  input  logic        buzzerOn,
  output logic [6:0]  hex5,
  output logic [6:0]  hex4,
  output logic [6:0]  hex3,
  output logic [6:0]  hex2,
  output logic [6:0]  hex1,
  output logic [6:0]  hex0,
  output logic        buzzer
);

  localparam int BW = $clog2(2 * BLINK_HALF_CYCLES);
  localparam logic [BW-1:0] BLINK_LAST = BW'(2 * BLINK_HALF_CYCLES - 1);
  localparam logic [BW-1:0] BLINK_HALF = BW'(BLINK_HALF_CYCLES);
  localparam int TW = $clog2(TONE_HALF_CYCLES + 1);
  localparam logic [TW-1:0] TONE_LAST = TW'(TONE_HALF_CYCLES - 1);

  state_t      state;
  logic [15:0] rem;
  logic [3:0]  min_r;
  logic [6:0]  sec_r;
  logic [6:0]  cs_r;
  logic [3:0]  min_t;
  logic [3:0]  sec_t;
  logic [3:0]  cs_t;
  logic        digit_done;

  logic [6:0]  seg5_d, seg4_d, seg3_d, seg2_d, seg1_d, seg0_d;
  logic [6:0]  hex5_q, hex4_q, hex3_q, hex2_q, hex1_q, hex0_q;

  logic [BW-1:0] blink_cnt;
  logic          blank_q;
  logic [TW-1:0] tone_cnt;

  assign digit_done = (min_r < 4'd10) && (sec_r < 7'd10) && (cs_r < 7'd10);

  // Decode the working digits; only latched into the display at COMMIT.
  seg7_decode u_seg5 (.digit(min_t),      .blank(min_t == 4'd0), .seg(seg5_d));
  seg7_decode u_seg4 (.digit(min_r),      .blank(1'b0),          .seg(seg4_d));
  seg7_decode u_seg3 (.digit(sec_t),      .blank(1'b0),          .seg(seg3_d));
  seg7_decode u_seg2 (.digit(sec_r[3:0]), .blank(1'b0),          .seg(seg2_d));
  seg7_decode u_seg1 (.digit(cs_t),       .blank(1'b0),          .seg(seg1_d));
  seg7_decode u_seg0 (.digit(cs_r[3:0]),  .blank(1'b0),          .seg(seg0_d));

  // Free-running conversion FSM; display registers change only in COMMIT.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= ST_SAMPLE;
      hex5_q <= SEG_BLANK;
      hex4_q <= SEG_BLANK;
      hex3_q <= SEG_BLANK;
      hex2_q <= SEG_BLANK;
      hex1_q <= SEG_BLANK;
      hex0_q <= SEG_BLANK;
    end else begin
      case (state)
        ST_SAMPLE: begin
          rem   <= value;
          min_r <= 4'd0;
          sec_r <= 7'd0;
          cs_r  <= 7'd0;
          min_t <= 4'd0;
          sec_t <= 4'd0;
          cs_t  <= 4'd0;
          state <= ST_MIN;
        end
        ST_MIN: begin
          if (rem >= CS_PER_MIN) begin
            rem   <= rem - CS_PER_MIN;
            min_r <= min_r + 4'd1;
          end else begin
            state <= ST_SEC;
          end
        end
        ST_SEC: begin
          if (rem >= CS_PER_SEC) begin
            rem   <= rem - CS_PER_SEC;
            sec_r <= sec_r + 7'd1;
          end else begin
            cs_r  <= rem[6:0];
            state <= ST_DIGIT;
          end
        end
        ST_DIGIT: begin
          if (min_r >= 4'd10) begin
            min_r <= min_r - 4'd10;
            min_t <= min_t + 4'd1;
          end
          if (sec_r >= 7'd10) begin
            sec_r <= sec_r - 7'd10;
            sec_t <= sec_t + 4'd1;
          end
          if (cs_r >= 7'd10) begin
            cs_r <= cs_r - 7'd10;
            cs_t <= cs_t + 4'd1;
          end
          if (digit_done) state <= ST_COMMIT;
        end
        ST_COMMIT: begin
          hex5_q <= seg5_d;
          hex4_q <= seg4_d;
          hex3_q <= seg3_d;
          hex2_q <= seg2_d;
          hex1_q <= seg1_d;
          hex0_q <= seg0_d;
          state  <= ST_SAMPLE;
        end
        default: state <= ST_SAMPLE;
      endcase
    end
  end

  // Blink phase counter; the off-phase blank flag lags the counter by one cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      blink_cnt <= '0;
      blank_q   <= 1'b0;
    end else begin
      if (!flashOn)                  blink_cnt <= '0;
      else if (blink_cnt == BLINK_LAST) blink_cnt <= '0;
      else                           blink_cnt <= blink_cnt + 1'b1;
      blank_q <= flashOn && (blink_cnt >= BLINK_HALF);
    end
  end

  assign hex5 = blank_q ? SEG_BLANK : hex5_q;
  assign hex4 = blank_q ? SEG_BLANK : hex4_q;
  assign hex3 = blank_q ? SEG_BLANK : hex3_q;
  assign hex2 = blank_q ? SEG_BLANK : hex2_q;
  assign hex1 = blank_q ? SEG_BLANK : hex1_q;
  assign hex0 = blank_q ? SEG_BLANK : hex0_q;

  // Square-wave tone: toggle every TONE_HALF_CYCLES while enabled, else idle low.
  always_ff @(posedge clk) begin
    if (reset || !buzzerOn) begin
      tone_cnt <= '0;
      buzzer   <= 1'b0;
    end else if (tone_cnt == TONE_LAST) begin
      tone_cnt <= '0;
      buzzer   <= ~buzzer;
    end else begin
      tone_cnt <= tone_cnt + 1'b1;
    end
  end

endmodule
